multicycle_sequencer: RTL and testbench

- Parametrised successor to the LEGv8 multi-cycle control unit's state logic.
- Sequences FETCH → EXEC(step 0..MAX_EX-1) → FETCH, owns the instruction register and handles memory wait states.
- Adds illegal-instruction and interrupt trapping and counts retired instructions.
- An external per-step decoder supplies the execute control words. This block selects between those words, fixed fetch/trap words, and stall-masked versions of each.

---
 rtl/seq_pkg.sv | 40 ++++
 rtl/retire_counter.sv | 31 +++
 rtl/multicycle_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared definitions for the multi-cycle sequencer: state
//                encoding, trap cause codes and LEGv8 write-enable positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Sequencer phases; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        TRAP  = 2'd2
    } seq_state_t;

    // Trap cause codes reported on the cause output.
    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_IRQ     = 2'd2
    } trap_cause_t;

    // Bit positions of the state-changing fields in the 34-bit LEGv8 control
    // word. These are the bits that must be suppressed while memory stalls.
    localparam int CW_BIT_RW  = 14;  // register file write
    localparam int CW_BIT_MW  = 13;  // data memory write
    localparam int CW_BIT_IL  = 16;  // instruction register load
    localparam int CW_BIT_PS0 = 17;  // PC select, low bit
    localparam int CW_BIT_PS1 = 18;  // PC select, high bit

    // Ready-made stall mask for the LEGv8 layout.
    localparam logic [33:0] LEGV8_WE_MASK = (34'd1 << CW_BIT_RW)  |
                                            (34'd1 << CW_BIT_MW)  |
                                            (34'd1 << CW_BIT_IL)  |
                                            (34'd1 << CW_BIT_PS0) |
                                            (34'd1 << CW_BIT_PS1);

endpackage : seq_pkg
`default_nettype wire

// File: rtl/retire_counter.sv
`default_nettype none
// ============================================================================
//  Module      : retire_counter
//  Description : Free-running increment-enable counter of retired
//                instructions. Wraps silently at its width.
//  Revision    : 1.0 - initial release
// ============================================================================
module retire_counter #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    output logic [COUNT_W-1:0] o_count
);

    logic [COUNT_W-1:0] r_count;

    // Count one per enabled cycle; natural overflow gives the wrap to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : retire_counter
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer
//  Description : FETCH -> EXEC(step 0..MAX_EX-1) -> FETCH sequencer with
//                instruction register, memory wait-state masking, illegal
//                instruction and interrupt trapping, and a retire counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int                CW_LEN  = 34,
    parameter int                MAX_EX  = 4,
    parameter int                STEP_W  = 3,
    parameter logic [CW_LEN-1:0] IF_CW   = '0,
    parameter logic [CW_LEN-1:0] TRAP_CW = '0,
    parameter logic [CW_LEN-1:0] WE_MASK = '0,
    parameter int                COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ready,
    input  logic               irq,
    input  logic [CW_LEN-1:0]  dec_cw,
    input  logic               dec_last,
    input  logic               dec_mem,
    input  logic               dec_illegal,
    output logic [CW_LEN-1:0]  control_word,
    output logic               mem_req,
    output logic [31:0]        ir,
    output logic [1:0]         state,
    output logic [STEP_W-1:0]  step,
    output logic               trap,
    output logic [1:0]         cause,
    output logic               seq_error,
    output logic [COUNT_W-1:0] retired
);

    localparam logic [STEP_W-1:0] c_last_step = STEP_W'(MAX_EX - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_nxt;
    logic [31:0]       r_ir;
    logic              w_ir_load;
    trap_cause_t       r_cause;
    trap_cause_t       w_cause_nxt;
    logic              r_seq_error;
    logic              w_seq_error_set;
    logic              r_irq_pending;
    logic              w_irq_clear;
    logic              w_irq_take;
    logic              w_final;
    logic              w_retire;
    logic              w_trap;

    // An interrupt arriving on the retiring cycle itself is taken immediately.
    assign w_irq_take = r_irq_pending | irq;

    // A step is final when the decoder says so or the step budget runs out.
    assign w_final = dec_last | (r_step == c_last_step);

    // Sequencer registers; reset returns everything to an idle FETCH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= FETCH;
            r_step        <= '0;
            r_ir          <= '0;
            r_cause       <= CAUSE_NONE;
            r_seq_error   <= 1'b0;
            r_irq_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_cause <= w_cause_nxt;
            if (w_ir_load) begin
                r_ir <= mem_rdata;
            end
            if (w_seq_error_set) begin
                r_seq_error <= 1'b1;
            end
            if (w_irq_clear) begin
                r_irq_pending <= 1'b0;
            end else if (irq) begin
                r_irq_pending <= 1'b1;
            end
        end
    end

    // Next-state, step advance and control word selection with stall masking.
    always_comb begin
        w_state_nxt     = r_state;
        w_step_nxt      = r_step;
        w_ir_load       = 1'b0;
        w_cause_nxt     = r_cause;
        w_seq_error_set = 1'b0;
        w_irq_clear     = 1'b0;
        w_retire        = 1'b0;
        w_trap          = 1'b0;
        control_word    = '0;
        mem_req         = 1'b0;

        case (r_state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    control_word = IF_CW;
                    w_ir_load    = 1'b1;
                    w_state_nxt  = EXEC;
                    w_step_nxt   = '0;
                end else begin
                    control_word = IF_CW & ~WE_MASK;
                end
            end

            EXEC: begin
                if ((r_step == '0) && dec_illegal) begin
                    // Nothing of the bad instruction may take effect.
                    control_word = '0;
                    w_state_nxt  = TRAP;
                    w_cause_nxt  = CAUSE_ILLEGAL;
                end else if (dec_mem && !mem_ready) begin
                    mem_req      = 1'b1;
                    control_word = dec_cw & ~WE_MASK;
                end else begin
                    control_word = dec_cw;
                    mem_req      = dec_mem;
                    if (w_final) begin
                        w_retire   = 1'b1;
                        w_step_nxt = '0;
                        if (!dec_last) begin
                            w_seq_error_set = 1'b1;
                        end
                        if (w_irq_take) begin
                            w_state_nxt = TRAP;
                            w_cause_nxt = CAUSE_IRQ;
                            w_irq_clear = 1'b1;
                        end else begin
                            w_state_nxt = FETCH;
                        end
                    end else begin
                        w_step_nxt = r_step + STEP_W'(1);
                    end
                end
            end

            TRAP: begin
                control_word = TRAP_CW;
                w_trap       = 1'b1;
                w_state_nxt  = FETCH;
            end

            default: begin
                w_state_nxt = FETCH;
                w_step_nxt  = '0;
            end
        endcase

        // A reset cycle must not disturb memory or the datapath.
        if (reset) begin
            control_word = '0;
            mem_req      = 1'b0;
            w_trap       = 1'b0;
        end
    end

    retire_counter #(
        .COUNT_W (COUNT_W)
    ) u_retire_counter (
        .clk     (clock),
        .rst     (reset),
        .i_en    (w_retire),
        .o_count (retired)
    );

    assign ir        = r_ir;
    assign state     = r_state;
    assign step      = r_step;
    assign trap      = w_trap;
    assign cause     = r_cause;
    assign seq_error = r_seq_error;

endmodule : multicycle_sequencer
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_sequencer
//  Description : Self-checking bench for multicycle_sequencer: directed
//                scenarios plus randomized cycles against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int          CW_LEN  = 34;
    localparam int          MAX_EX  = 4;
    localparam int          STEP_W  = 3;
    localparam int          COUNT_W = 4;
    localparam logic [33:0] IF_CW   = 34'h1_2345_678F;
    localparam logic [33:0] TRAP_CW = 34'h2_DEAD_BEEF;
    localparam logic [33:0] WE_MASK = 34'h3_0000_F00F;

    logic               clock;
    logic               reset;
    logic [31:0]        mem_rdata;
    logic               mem_ready;
    logic               irq;
    logic [CW_LEN-1:0]  dec_cw;
    logic               dec_last;
    logic               dec_mem;
    logic               dec_illegal;
    logic [CW_LEN-1:0]  control_word;
    logic               mem_req;
    logic [31:0]        ir;
    logic [1:0]         state;
    logic [STEP_W-1:0]  step;
    logic               trap;
    logic [1:0]         cause;
    logic               seq_error;
    logic [COUNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_sequencer #(
        .CW_LEN  (CW_LEN),
        .MAX_EX  (MAX_EX),
        .STEP_W  (STEP_W),
        .IF_CW   (IF_CW),
        .TRAP_CW (TRAP_CW),
        .WE_MASK (WE_MASK),
        .COUNT_W (COUNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .irq          (irq),
        .dec_cw       (dec_cw),
        .dec_last     (dec_last),
        .dec_mem      (dec_mem),
        .dec_illegal  (dec_illegal),
        .control_word (control_word),
        .mem_req      (mem_req),
        .ir           (ir),
        .state        (state),
        .step         (step),
        .trap         (trap),
        .cause        (cause),
        .seq_error    (seq_error),
        .retired      (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_inputs();
        mem_ready   = 1'b1;
        irq         = 1'b0;
        dec_cw      = '0;
        dec_last    = 1'b0;
        dec_mem     = 1'b0;
        dec_illegal = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One ready fetch cycle; afterwards the DUT sits in EXEC step 0.
    task automatic fetch_instr(input logic [31:0] word);
        quiet_inputs();
        mem_rdata = word;
        tick();
    endtask

    task automatic test_reset();
        quiet_inputs();
        dec_cw = 34'h3_FFFF_FFFF;
        reset  = 1'b1;
        #1;
        checks++;
        if (control_word !== '0) begin errors++; $display("FAIL reset_cw: got %h expected 0", control_word); end
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        tick();
        checks++;
        if ({state, step, cause, seq_error, trap} !== '0 || ir !== '0 || retired !== '0) begin
            errors++;
            $display("FAIL reset_regs: got state=%0d step=%0d cause=%0d err=%b trap=%b ir=%h ret=%0d expected all 0",
                     state, step, cause, seq_error, trap, ir, retired);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_flow();
        logic [33:0] cw;
        do_reset();
        mem_rdata = 32'h8B02_0020;
        #1;
        checks++;
        if (state !== 2'd0 || control_word !== IF_CW || mem_req !== 1'b1) begin
            errors++; $display("FAIL basic_fetch: got state=%0d cw=%h req=%b expected 0 %h 1", state, control_word, mem_req, IF_CW);
        end
        tick();
        checks++;
        if (state !== 2'd1 || step !== 3'd0 || ir !== 32'h8B02_0020) begin
            errors++; $display("FAIL basic_ir: got state=%0d step=%0d ir=%h expected 1 0 8b020020", state, step, ir);
        end
        cw = 34'h3_FFFF_FFFF;
        dec_cw = cw;
        #1;
        checks++;
        if (control_word !== cw || mem_req !== 1'b0) begin
            errors++; $display("FAIL basic_step0_cw: got %h req=%b expected %h 0", control_word, mem_req, cw);
        end
        tick();
        checks++;
        if (state !== 2'd1 || step !== 3'd1) begin
            errors++; $display("FAIL basic_step1: got state=%0d step=%0d expected 1 1", state, step);
        end
        dec_last = 1'b1;
        tick();
        checks++;
        if (state !== 2'd0 || retired !== 4'd1 || step !== 3'd0) begin
            errors++; $display("FAIL basic_retire: got state=%0d retired=%0d step=%0d expected 0 1 0", state, retired, step);
        end
    endtask

    task automatic test_fetch_stall();
        logic [31:0] word;
        do_reset();
        word      = $urandom();
        mem_rdata = word;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (control_word !== (IF_CW & ~WE_MASK) || mem_req !== 1'b1) begin
                errors++; $display("FAIL fetch_stall_cw[%0d]: got %h req=%b expected %h 1", i, control_word, mem_req, IF_CW & ~WE_MASK);
            end
            tick();
            checks++;
            if (state !== 2'd0 || ir !== 32'd0) begin
                errors++; $display("FAIL fetch_stall_hold[%0d]: got state=%0d ir=%h expected 0 0", i, state, ir);
            end
        end
        mem_ready = 1'b1;
        tick();
        checks++;
        if (state !== 2'd1 || ir !== word) begin
            errors++; $display("FAIL fetch_stall_load: got state=%0d ir=%h expected 1 %h", state, ir, word);
        end
    endtask

    task automatic test_load_stall();
        logic [33:0] cw;
        do_reset();
        fetch_instr($urandom());
        tick();
        cw        = 34'h3_ABCD_F0FF;
        dec_cw    = cw;
        dec_mem   = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (control_word !== (cw & ~WE_MASK) || mem_req !== 1'b1) begin
                errors++; $display("FAIL load_stall_cw[%0d]: got %h req=%b expected %h 1", i, control_word, mem_req, cw & ~WE_MASK);
            end
            tick();
            checks++;
            if (state !== 2'd1 || step !== 3'd1) begin
                errors++; $display("FAIL load_stall_hold[%0d]: got state=%0d step=%0d expected 1 1", i, state, step);
            end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (control_word !== cw || mem_req !== 1'b1) begin
            errors++; $display("FAIL load_ready_cw: got %h req=%b expected %h 1", control_word, mem_req, cw);
        end
        tick();
        checks++;
        if (step !== 3'd2) begin
            errors++; $display("FAIL load_advance: got step=%0d expected 2", step);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        fetch_instr(32'hFFFF_FFFF);
        dec_illegal = 1'b1;
        dec_cw      = 34'h1_1111_1111;
        #1;
        checks++;
        if (control_word !== '0) begin
            errors++; $display("FAIL illegal_cw: got %h expected 0", control_word);
        end
        tick();
        dec_illegal = 1'b0;
        #1;
        checks++;
        if (state !== 2'd2 || trap !== 1'b1 || cause !== 2'd1 || control_word !== TRAP_CW || mem_req !== 1'b0 || retired !== 4'd0) begin
            errors++; $display("FAIL illegal_trap: got state=%0d trap=%b cause=%0d cw=%h req=%b ret=%0d expected 2 1 1 %h 0 0",
                               state, trap, cause, control_word, mem_req, retired, TRAP_CW);
        end
        tick();
        checks++;
        if (state !== 2'd0 || trap !== 1'b0) begin
            errors++; $display("FAIL illegal_exit: got state=%0d trap=%b expected 0 0", state, trap);
        end
    endtask

    task automatic test_irq();
        do_reset();
        fetch_instr($urandom());
        irq = 1'b1;
        tick();
        irq      = 1'b0;
        dec_last = 1'b1;
        tick();
        dec_last = 1'b0;
        checks++;
        if (state !== 2'd2 || cause !== 2'd2 || trap !== 1'b1 || retired !== 4'd1) begin
            errors++; $display("FAIL irq_trap: got state=%0d cause=%0d trap=%b ret=%0d expected 2 2 1 1", state, cause, trap, retired);
        end
        tick();
        fetch_instr($urandom());
        dec_illegal = 1'b1;
        irq         = 1'b1;
        tick();
        dec_illegal = 1'b0;
        irq         = 1'b0;
        checks++;
        if (state !== 2'd2 || cause !== 2'd1 || retired !== 4'd1) begin
            errors++; $display("FAIL irq_illegal_first: got state=%0d cause=%0d ret=%0d expected 2 1 1", state, cause, retired);
        end
        tick();
        fetch_instr($urandom());
        dec_last = 1'b1;
        tick();
        checks++;
        if (state !== 2'd2 || cause !== 2'd2 || retired !== 4'd2) begin
            errors++; $display("FAIL irq_deferred: got state=%0d cause=%0d ret=%0d expected 2 2 2", state, cause, retired);
        end
        tick();
        fetch_instr($urandom());
        dec_last = 1'b1;
        tick();
        checks++;
        if (state !== 2'd0 || cause !== 2'd2 || retired !== 4'd3) begin
            errors++; $display("FAIL irq_cleared: got state=%0d cause=%0d ret=%0d expected 0 2 3", state, cause, retired);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fetch_instr($urandom());
        for (int s = 1; s < MAX_EX; s++) begin
            tick();
            checks++;
            if (state !== 2'd1 || step !== 3'(s) || seq_error !== 1'b0) begin
                errors++; $display("FAIL overflow_step[%0d]: got state=%0d step=%0d err=%b expected 1 %0d 0", s, state, step, seq_error, s);
            end
        end
        tick();
        checks++;
        if (state !== 2'd0 || step !== 3'd0 || seq_error !== 1'b1 || retired !== 4'd1) begin
            errors++; $display("FAIL overflow_force: got state=%0d step=%0d err=%b ret=%0d expected 0 0 1 1", state, step, seq_error, retired);
        end
        fetch_instr($urandom());
        dec_last = 1'b1;
        tick();
        checks++;
        if (seq_error !== 1'b1 || retired !== 4'd2) begin
            errors++; $display("FAIL overflow_sticky: got err=%b ret=%0d expected 1 2", seq_error, retired);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            fetch_instr($urandom());
            dec_last = 1'b1;
            tick();
            if (n == 15 || n == 16) begin
                checks++;
                if (retired !== 4'(n % 16)) begin
                    errors++; $display("FAIL wrap[%0d]: got retired=%0d expected %0d", n, retired, n % 16);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        mem_ready = 1'b0;
        irq       = 1'b1;
        tick();
        fetch_instr($urandom());
        dec_mem   = 1'b1;
        mem_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || control_word !== '0) begin
            errors++; $display("FAIL midstall_outputs: got req=%b cw=%h expected 0 0", mem_req, control_word);
        end
        tick();
        reset = 1'b0;
        checks++;
        if (state !== 2'd0 || step !== 3'd0 || cause !== 2'd0 || seq_error !== 1'b0 || trap !== 1'b0 || retired !== 4'd0) begin
            errors++; $display("FAIL midstall_regs: got state=%0d step=%0d cause=%0d err=%b trap=%b ret=%0d expected all 0",
                               state, step, cause, seq_error, trap, retired);
        end
        fetch_instr($urandom());
        dec_last = 1'b1;
        tick();
        checks++;
        if (state !== 2'd0) begin
            errors++; $display("FAIL midstall_irq_dropped: got state=%0d expected 0", state);
        end
    endtask

    // Randomized cycles against a phase-level model of the sequencer rules.
    task automatic test_random();
        int          m_phase;   // 0 fetch, 1 exec, 2 trap
        int          m_step;
        logic [31:0] m_ir;
        int          m_cause;
        bit          m_err;
        bit          m_pend;
        int          m_ret;
        bit          pend_next;
        bit          chk_req;
        logic [33:0] e_cw;
        logic        e_req;
        do_reset();
        m_phase = 0; m_step = 0; m_ir = '0; m_cause = 0; m_err = 0; m_pend = 0; m_ret = 0;
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(99) < 2);
            mem_ready   = ($urandom_range(3) != 0);
            irq         = ($urandom_range(19) == 0);
            dec_last    = ($urandom_range(2) == 0);
            dec_mem     = ($urandom_range(3) == 0);
            dec_illegal = ($urandom_range(9) == 0);
            mem_rdata   = $urandom();
            dec_cw      = 34'({$urandom(), $urandom()});

            chk_req = 1'b1;
            e_cw    = '0;
            e_req   = 1'b0;
            if (!reset) begin
                if (m_phase == 0) begin
                    e_req = 1'b1;
                    e_cw  = mem_ready ? IF_CW : (IF_CW & ~WE_MASK);
                end else if (m_phase == 1) begin
                    if (m_step == 0 && dec_illegal) begin
                        chk_req = 1'b0;
                    end else if (dec_mem && !mem_ready) begin
                        e_req = 1'b1;
                        e_cw  = dec_cw & ~WE_MASK;
                    end else begin
                        e_req = dec_mem;
                        e_cw  = dec_cw;
                    end
                end else begin
                    e_cw = TRAP_CW;
                end
            end
            #1;
            checks++;
            if (control_word !== e_cw) begin
                errors++; $display("FAIL rand_cw[%0d]: got %h expected %h", n, control_word, e_cw);
            end
            if (chk_req) begin
                checks++;
                if (mem_req !== e_req) begin
                    errors++; $display("FAIL rand_req[%0d]: got %b expected %b", n, mem_req, e_req);
                end
            end

            if (reset) begin
                m_phase = 0; m_step = 0; m_ir = '0; m_cause = 0; m_err = 0; m_pend = 0; m_ret = 0;
            end else begin
                pend_next = m_pend | irq;
                if (m_phase == 0) begin
                    if (mem_ready) begin
                        m_ir = mem_rdata; m_phase = 1; m_step = 0;
                    end
                end else if (m_phase == 1) begin
                    if (m_step == 0 && dec_illegal) begin
                        m_phase = 2; m_cause = 1;
                    end else if (!(dec_mem && !mem_ready)) begin
                        if (dec_last || m_step == MAX_EX - 1) begin
                            if (!dec_last) m_err = 1;
                            m_ret  = (m_ret + 1) % 16;
                            m_step = 0;
                            if (pend_next) begin
                                m_phase = 2; m_cause = 2; pend_next = 0;
                            end else begin
                                m_phase = 0;
                            end
                        end else begin
                            m_step = m_step + 1;
                        end
                    end
                end else begin
                    m_phase = 0;
                end
                m_pend = pend_next;
            end
            tick();
            checks++;
            if (state !== 2'(m_phase) || step !== 3'(m_step) || ir !== m_ir || cause !== 2'(m_cause) ||
                seq_error !== m_err || retired !== 4'(m_ret) || trap !== (m_phase == 2)) begin
                errors++;
                $display("FAIL rand_regs[%0d]: got st=%0d step=%0d ir=%h cause=%0d err=%b ret=%0d trap=%b expected %0d %0d %h %0d %b %0d %b",
                         n, state, step, ir, cause, seq_error, retired, trap,
                         m_phase, m_step, m_ir, m_cause, m_err, m_ret, (m_phase == 2));
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        mem_rdata = '0;
        quiet_inputs();
        tick();
        test_reset();
        test_basic_flow();
        test_fetch_stall();
        test_load_stall();
        test_illegal();
        test_irq();
        test_overflow();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multicycle_sequencer
`default_nettype wire
